// File: rtl/ad9866_pkg.sv
// rtl/ad9866_pkg.sv - AD9866 control-port constants, init table, FSM states and frame builder
package ad9866_pkg;

  localparam int INIT_LEN = 8;

  localparam int FRAME_RW_BIT    = 15;
  localparam int FRAME_LEN_HI    = 14;
  localparam int FRAME_LEN_LO    = 13;
  localparam int FRAME_ADDR_HI   = 12;
  localparam int FRAME_ADDR_LO   = 8;
  localparam logic [1:0] FRAME_LEN_1BYTE = 2'b00;

  // {addr[4:0], data[7:0]} written once after the codec leaves reset
  localparam logic [0:INIT_LEN-1][12:0] INIT_TABLE = {
    13'h0080, 13'h0436, 13'h0540, 13'h0600,
    13'h0721, 13'h084B, 13'h0E81, 13'h1084
  };

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  function automatic logic [15:0] make_frame(input logic rw, input logic [4:0] addr,
                                             input logic [7:0] data);
    logic [15:0] f;
    f = '0;
    f[FRAME_RW_BIT] = rw;
    f[FRAME_LEN_HI:FRAME_LEN_LO] = FRAME_LEN_1BYTE;
    f[FRAME_ADDR_HI:FRAME_ADDR_LO] = addr;
    f[7:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/ad9866_spi_ctrl_if.sv
// rtl/ad9866_spi_ctrl_if.sv - host/gain request ports and readback of the AD9866 controller
interface ad9866_spi_ctrl_if;
  logic       h_valid;
  logic       h_ready;
  logic       h_rw;
  logic [4:0] h_addr;
  logic [7:0] h_wdata;
  logic       g_valid;
  logic       g_ready;
  logic [4:0] g_addr;
  logic [7:0] g_wdata;
  logic [7:0] rdata;
  logic       rdata_valid;

  modport master (
    output h_valid, h_rw, h_addr, h_wdata, g_valid, g_addr, g_wdata,
    input  h_ready, g_ready, rdata, rdata_valid
  );

  modport slave (
    input  h_valid, h_rw, h_addr, h_wdata, g_valid, g_addr, g_wdata,
    output h_ready, g_ready, rdata, rdata_valid
  );
endinterface

// File: rtl/ad9866_spi_ctrl_spi_shift16.sv
// rtl/ad9866_spi_ctrl_spi_shift16.sv - 16-bit SPI frame serializer with sdo capture
module spi_shift16 #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        sclk,
  output logic        sdio,
  output logic        sen_n,
  input  logic        sdo
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // half 0 is the setup half before the first rise, odd halves are SCLK high, half 32 is the tail
  logic             active;
  logic [5:0]       half;
  logic [DIV_W-1:0] div;
  logic [15:0]      tx_sr;
  logic [7:0]       rx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      half   <= '0;
      div    <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active <= 1'b1;
          half   <= '0;
          div    <= '0;
          tx_sr  <= tx_data;
        end
      end else begin
        if (half[0] && div == '0)
          rx_sr <= {rx_sr[6:0], sdo};
        if (div == DIV_LAST) begin
          div <= '0;
          if (half[0])
            tx_sr <= {tx_sr[14:0], 1'b0};
          if (half == 6'd32) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            half <= half + 6'd1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  assign sclk    = active & half[0];
  assign sdio    = active & tx_sr[15];
  assign sen_n   = ~active;
  assign rx_data = rx_sr;

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// rtl/ad9866_spi_ctrl.sv - AD9866 reset/init sequencer and host/gain SPI access arbiter
module ad9866_spi_ctrl
  import ad9866_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 1024,
  parameter int WAIT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  ad9866_spi_ctrl_if.slave        bus,
  output logic                    init_done,
  output logic                    busy,
  output logic                    ad9866_rst_n,
  output logic                    ad9866_sclk,
  output logic                    ad9866_sdio,
  input  logic                    ad9866_sdo,
  output logic                    ad9866_sen_n
);

  localparam int CNT_A   = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CNT_MAX = (CNT_A > 2 * CLK_DIV) ? CNT_A : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(INIT_LEN);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   init_idx;
  logic               prefer_g;
  logic               cur_rw;
  logic               start;
  logic [15:0]        tx_frame;
  logic               grant_h, grant_g;
  logic               spi_done;
  logic [7:0]         spi_rx;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    tx_frame = '0;
    grant_h  = 1'b0;
    grant_g  = 1'b0;
    case (state)
      ST_RST_HOLD: if (cnt == CNT_W'(RST_CYCLES - 1)) state_nx = ST_RST_WAIT;
      // one cycle of the wait is spent in INIT so the first frame starts exactly WAIT_CYCLES later
      ST_RST_WAIT: if (cnt == CNT_W'(WAIT_CYCLES - 2)) state_nx = ST_INIT;
      ST_INIT: begin
        start    = 1'b1;
        tx_frame = make_frame(1'b0, INIT_TABLE[init_idx][12:8], INIT_TABLE[init_idx][7:0]);
        state_nx = ST_SHIFT;
      end
      ST_IDLE: begin
        grant_g = bus.g_valid && (!bus.h_valid || prefer_g);
        grant_h = bus.h_valid && !grant_g;
        if (grant_g) begin
          start    = 1'b1;
          tx_frame = make_frame(1'b0, bus.g_addr, bus.g_wdata);
          state_nx = ST_SHIFT;
        end else if (grant_h) begin
          start    = 1'b1;
          tx_frame = make_frame(bus.h_rw, bus.h_addr, bus.h_rw ? 8'h00 : bus.h_wdata);
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: if (spi_done) state_nx = ST_GAP;
      ST_GAP: begin
        if (cnt == CNT_W'(2 * CLK_DIV - 1)) begin
          if (!init_done && init_idx != IDX_W'(INIT_LEN - 1)) state_nx = ST_INIT;
          else state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RST_HOLD;
      cnt             <= '0;
      init_idx        <= '0;
      init_done       <= 1'b0;
      prefer_g        <= 1'b1;
      cur_rw          <= 1'b0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
      if (state == ST_GAP && state_nx == ST_INIT) init_idx <= init_idx + 1'b1;
      if (state == ST_GAP && state_nx == ST_IDLE) init_done <= 1'b1;
      if (grant_g) prefer_g <= 1'b0;
      if (grant_h) prefer_g <= 1'b1;
      if (start) cur_rw <= tx_frame[FRAME_RW_BIT];
      bus.rdata_valid <= spi_done && cur_rw;
      if (spi_done && cur_rw) bus.rdata <= spi_rx;
    end
  end

  assign bus.h_ready  = grant_h;
  assign bus.g_ready  = grant_g;
  assign busy         = (state != ST_IDLE);
  assign ad9866_rst_n = (state != ST_RST_HOLD);

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_frame),
    .done    (spi_done),
    .rx_data (spi_rx),
    .sclk    (ad9866_sclk),
    .sdio    (ad9866_sdio),
    .sen_n   (ad9866_sen_n),
    .sdo     (ad9866_sdo)
  );

endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
// tb/tb_ad9866_spi_ctrl.sv - directed self-checking bench for ad9866_spi_ctrl
module tb_ad9866_spi_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done, busy, rst_n, sclk, sdio, sen_n;
  logic sdo = 1'b0;

  ad9866_spi_ctrl_if bus_if ();

  ad9866_spi_ctrl #(.CLK_DIV(2), .RST_CYCLES(16), .WAIT_CYCLES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .init_done    (init_done),
    .busy         (busy),
    .ad9866_rst_n (rst_n),
    .ad9866_sclk  (sclk),
    .ad9866_sdio  (sdio),
    .ad9866_sdo   (sdo),
    .ad9866_sen_n (sen_n)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_init [8] = '{16'h0080, 16'h0436, 16'h0540, 16'h0600,
                                16'h0721, 16'h084B, 16'h0E81, 16'h1084};

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI bus model: decodes frames on SCLK rises, drives read data on SCLK falls
  logic [15:0] frames [$];
  int          lens [$];
  logic [15:0] shreg;
  logic [7:0]  rd_byte = 8'h00;
  logic        prev_sen = 1'b1, prev_sclk = 1'b0, have_rise = 1'b0;
  int cyc = 0, fall_cyc = 0, rise_cyc = 0, bits = 0, min_gap = 1000;
  int rv_cnt = 0, rv_cyc = 0, ready_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (prev_sen && !sen_n) begin
      fall_cyc = cyc;
      shreg = '0;
      bits = 0;
      sdo = 1'b0;
      if (have_rise && (cyc - rise_cyc) < min_gap) min_gap = cyc - rise_cyc;
    end
    if (!sen_n && sclk && !prev_sclk) begin
      shreg = {shreg[14:0], sdio};
      bits++;
    end
    if (!sen_n && !sclk && prev_sclk)
      sdo = (bits >= 8 && bits <= 15) ? rd_byte[15 - bits] : 1'b0;
    if (!prev_sen && sen_n) begin
      rise_cyc = cyc;
      have_rise = 1'b1;
      frames.push_back(shreg);
      lens.push_back(cyc - fall_cyc);
    end
    if (bus_if.rdata_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
    if ((bus_if.h_ready || bus_if.g_ready) && busy) ready_bad++;
    prev_sen = sen_n;
    prev_sclk = sclk;
  end

  task automatic host_req(input logic rw, input logic [4:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    bus_if.h_rw = rw;
    bus_if.h_addr = a;
    bus_if.h_wdata = d;
    bus_if.h_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = bus_if.h_ready;
    end
    @(posedge clk);
    #1 bus_if.h_valid = 1'b0;
    check("h_grant", got, 1);
  endtask

  task automatic wait_frames(input int n, input string tag);
    for (int i = 0; i < 2000 && frames.size() < n; i++) @(negedge clk);
    check(tag, frames.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("busy_idle", busy, 0);
  endtask

  task automatic run_init(input bit with_g);
    int lowc, w;
    bit seen;
    frames.delete();
    lens.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    lowc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!rst_n) lowc++;
      else seen = 1'b1;
    end
    check("rst_n_low_cycles", lowc, 16);
    w = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      w++;
      seen = !sen_n;
    end
    check("first_fall_delay", w, 32);
    if (with_g) begin
      @(posedge clk);
      #1;
      bus_if.g_addr = 5'h15;
      bus_if.g_wdata = 8'hC3;
      bus_if.g_valid = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = init_done;
    end
    check("init_done", init_done, 1);
    check("frames_at_init_done", frames.size(), 8);
    check("busy_after_init", busy, 0);
    if (with_g) begin
      check("g_grant_at_idle", bus_if.g_ready, 1);
      @(posedge clk);
      #1 bus_if.g_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      check("init_frame", frames[i], exp_init[i]);
      check("init_sen_low", lens[i], 66);
    end
  endtask

  initial begin
    logic [23:0] seq;
    int ng, rv0;
    bus_if.h_valid = 1'b0;
    bus_if.h_rw = 1'b0;
    bus_if.h_addr = '0;
    bus_if.h_wdata = '0;
    bus_if.g_valid = 1'b0;
    bus_if.g_addr = '0;
    bus_if.g_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {rst_n, sclk, sdio, sen_n, bus_if.h_ready, bus_if.g_ready, bus_if.rdata_valid,
           init_done, busy}, 9'b000100001);
    check("reset_rdata", bus_if.rdata, 8'h00);

    run_init(1'b0);

    // host write
    frames.delete();
    lens.delete();
    host_req(1'b0, 5'h0A, 8'h5C);
    wait_frames(1, "wr_frame_count");
    check("wr_frame", frames[0], 16'h0A5C);
    check("wr_sen_low", lens[0], 66);
    wait_idle();

    // host read
    frames.delete();
    lens.delete();
    rd_byte = 8'hA7;
    rv0 = rv_cnt;
    host_req(1'b1, 5'h1F, 8'hFF);
    wait_frames(1, "rd_frame_count");
    check("rd_instr", frames[0][15:8], 8'h9F);
    check("rd_data_phase", frames[0][7:0], 8'h00);
    repeat (6) @(negedge clk);
    check("rdata", bus_if.rdata, 8'hA7);
    check("rdata_valid_pulses", rv_cnt - rv0, 1);
    check("rdata_valid_timing", rv_cyc - rise_cyc, 1);
    wait_idle();

    // simultaneous requests, held
    frames.delete();
    lens.delete();
    min_gap = 1000;
    seq = '0;
    ng = 0;
    @(posedge clk);
    #1;
    bus_if.h_rw = 1'b0;
    bus_if.h_addr = 5'h01;
    bus_if.h_wdata = 8'h11;
    bus_if.g_addr = 5'h02;
    bus_if.g_wdata = 8'h22;
    bus_if.h_valid = 1'b1;
    bus_if.g_valid = 1'b1;
    for (int i = 0; i < 1000 && ng < 3; i++) begin
      @(negedge clk);
      if (bus_if.g_ready) begin seq = {seq[15:0], 8'h47}; ng++; end
      if (bus_if.h_ready) begin seq = {seq[15:0], 8'h48}; ng++; end
    end
    @(posedge clk);
    #1;
    bus_if.h_valid = 1'b0;
    bus_if.g_valid = 1'b0;
    check("rr_order", seq, 24'h474847);
    wait_frames(3, "rr_frame_count");
    check("rr_frame0", frames[0], 16'h0222);
    check("rr_frame1", frames[1], 16'h0111);
    check("rr_frame2", frames[2], 16'h0222);
    check("rr_min_gap_ok", min_gap >= 4, 1);
    wait_idle();

    // reset in the middle of a frame, then replay init with a pending gain request
    host_req(1'b0, 5'h03, 8'h33);
    for (int i = 0; i < 200 && bits != 7; i++) @(negedge clk);
    check("abort_at_bit7", bits, 7);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_pins", {sen_n, sclk, rst_n, busy}, 4'b1001);
    repeat (2) @(posedge clk);
    run_init(1'b1);
    wait_frames(9, "g_frame_count");
    check("g_frame_after_init", frames[8], 16'h15C3);
    wait_idle();

    check("ready_while_busy", ready_bad, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
